// File: rtl/lane_unstripe_n_if.sv
// Signal bundle between the lane side and the merged side of lane_unstripe_n.
// The DUT takes the slave view. A lane source / merged sink takes the master view.
interface lane_unstripe_n_if #(
  parameter int DATA_W    = 32,
  parameter int NUM_LANES = 4
);
  logic [3:0]                  active_lanes;
  logic [NUM_LANES*DATA_W-1:0] lane_data;
  logic [NUM_LANES-1:0]        lane_valid;
  logic [NUM_LANES-1:0]        lane_ready;
  logic [NUM_LANES-1:0]        lane_err;
  logic [DATA_W-1:0]           data_out;
  logic                        valid_out;
  logic                        ready_out;

  modport master (
    output active_lanes, lane_data, lane_valid, ready_out,
    input  lane_ready, lane_err, data_out, valid_out
  );

  modport slave (
    input  active_lanes, lane_data, lane_valid, ready_out,
    output lane_ready, lane_err, data_out, valid_out
  );
endinterface

// File: rtl/lane_unstripe_n.sv
// Lane un-striper.
// Each lane writes into its own small FIFO. A round-robin pointer (sel) merges
// the heads back into one stream in the order lane0, lane1, ... lane N-1, lane0.
// If lane sel is empty, the merge stalls until that lane catches up. It never
// skips a lane, so the original stripe order is preserved.
module lane_unstripe_n #(
  parameter int DATA_W    = 32,
  parameter int NUM_LANES = 4,
  parameter int DEPTH     = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  lane_unstripe_n_if.slave bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int SEL_W  = $clog2(NUM_LANES);
  localparam int MODE_W = 4;

  localparam logic [CNT_W-1:0]  FULL     = CNT_W'(DEPTH);
  localparam logic [MODE_W-1:0] MAX_MODE = MODE_W'(NUM_LANES);

  // Per-lane FIFO storage and bookkeeping.
  logic [DATA_W-1:0] mem    [NUM_LANES][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NUM_LANES];
  logic [PTR_W-1:0]  rd_ptr [NUM_LANES];
  logic [CNT_W-1:0]  count  [NUM_LANES];

  logic [NUM_LANES-1:0] err_q;
  logic [SEL_W-1:0]     sel;
  logic [MODE_W-1:0]    n_eff;     // clamped lane count requested right now
  logic [MODE_W-1:0]    n_eff_q;   // lane count the merge currently runs with

  logic [NUM_LANES-1:0] ready;
  logic [NUM_LANES-1:0] push;
  logic [NUM_LANES-1:0] drop;
  logic [NUM_LANES-1:0] pop_lane;
  logic                 all_empty;
  logic                 valid;
  logic                 pop;
  logic                 wrap;
  logic [DATA_W-1:0]    head;

  // Clamp the requested mode. Zero means a single lane. Values above the lane count saturate.
  always_comb begin
    // NOTE: every branch assigns n_eff, so this block stays combinational.
    // It must not become a latch.
    if (bus.active_lanes == '0) begin
      n_eff = MODE_W'(1);
    end else if (bus.active_lanes > MAX_MODE) begin
      n_eff = MAX_MODE;
    end else begin
      n_eff = bus.active_lanes;
    end
  end

  // Lane-side flow control: a lane has space if it is in the latched mode and its FIFO is not full.
  always_comb begin
    all_empty = 1'b1;
    for (int i = 0; i < NUM_LANES; i++) begin
      ready[i] = (count[i] != FULL) && (MODE_W'(i) < n_eff_q);
      push[i]  = bus.lane_valid[i] && ready[i];
      drop[i]  = bus.lane_valid[i] && !ready[i];
      if (count[i] != '0) begin
        all_empty = 1'b0;
      end
    end
  end

  // Merge side: present the head of lane sel. On a pop, the round-robin moves forward.
  always_comb begin
    valid    = (count[sel] != '0);
    head     = mem[sel][rd_ptr[sel]];
    pop      = valid && bus.ready_out;
    wrap     = pop && (MODE_W'(sel) == (n_eff_q - MODE_W'(1)));
    pop_lane = '0;
    if (pop) begin
      pop_lane[sel] = 1'b1;
    end
  end

  assign bus.lane_ready = ready;
  assign bus.lane_err   = err_q;
  assign bus.valid_out  = valid;
  // An empty head is forced to zero.
  // This keeps data_out clean in reset and hides stale storage.
  assign bus.data_out   = valid ? head : '0;

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the data array has no reset. The count/pointer state decides what is valid.
    // Clearing the words would only add reset fan-out.
    for (int i = 0; i < NUM_LANES; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= bus.lane_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // FIFO pointers and counts, plus sticky per-lane error flags.
  // A same-cycle push and pop moves both pointers and leaves the count unchanged.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      err_q <= '0;
    end else begin
      // NOTE: all state updates use non-blocking assignment.
      // Every lane then sees the pre-edge values of sel/count, whatever the loop order.
      for (int i = 0; i < NUM_LANES; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        end
        if (pop_lane[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        end
        if (push[i] && !pop_lane[i]) begin
          count[i] <= count[i] + CNT_W'(1);
        end else if (!push[i] && pop_lane[i]) begin
          count[i] <= count[i] - CNT_W'(1);
        end
      end
      err_q <= err_q | drop;
    end
  end

  // Round-robin pointer and mode latch.
  // A new mode is applied only at a stripe boundary (wrap to lane 0) or when nothing is
  // buffered, so a stripe in flight is never split across two modes.
  // The reset branch loads the live clamped mode. Coming out of reset, the block then
  // runs with whatever mode is requested at release.
  // If the FIFOs are empty and sel is outside the new mode, sel returns to lane 0.
  // Otherwise it would wait on a lane that can no longer accept words.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sel     <= '0;
      n_eff_q <= n_eff;
    end else begin
      if (wrap) begin
        sel <= '0;
      end else if (pop) begin
        sel <= sel + SEL_W'(1);
      end else if (all_empty && (MODE_W'(sel) >= n_eff)) begin
        sel <= '0;
      end
      if (wrap || all_empty) begin
        n_eff_q <= n_eff;
      end
    end
  end

endmodule

// File: tb/tb_lane_unstripe_n.sv
// Bench for lane_unstripe_n.
// Directed scenarios use constant expectations. A randomized run compares every cycle
// against a queue-based model of the striping rules.
module tb_lane_unstripe_n;

  localparam int DATA_W    = 32;
  localparam int NUM_LANES = 4;
  localparam int DEPTH     = 4;

  typedef logic [DATA_W-1:0]           word_t;
  typedef logic [NUM_LANES-1:0]        lanes_t;
  typedef logic [NUM_LANES*DATA_W-1:0] beat_t;

  logic clk     = 1'b0;
  logic reset_L = 1'b0;
  int   passed  = 0;
  int   total   = 0;

  lane_unstripe_n_if #(.DATA_W(DATA_W), .NUM_LANES(NUM_LANES)) bus ();

  lane_unstripe_n #(.DATA_W(DATA_W), .NUM_LANES(NUM_LANES), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per lane, the lane the merge is waiting on, and the applied mode.
  word_t  mq [NUM_LANES][$];
  int     m_sel;
  int     m_nlat;
  lanes_t m_err;
  word_t  got [$];

  function automatic int clamp_mode(input logic [3:0] a);
    if (a == 4'd0) return 1;
    if (int'(a) > NUM_LANES) return NUM_LANES;
    return int'(a);
  endfunction

  function automatic lanes_t m_ready();
    lanes_t r;
    for (int i = 0; i < NUM_LANES; i++) r[i] = (mq[i].size() < DEPTH) && (i < m_nlat);
    return r;
  endfunction

  function automatic logic m_valid();
    return mq[m_sel].size() != 0;
  endfunction

  function automatic word_t m_head();
    return (mq[m_sel].size() != 0) ? mq[m_sel][0] : '0;
  endfunction

  function automatic beat_t pk(input word_t w0, input word_t w1, input word_t w2, input word_t w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic word_t w(input int lane, input int beat);
    return word_t'(lane * 256 + beat);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_LANES; i++) mq[i].delete();
    m_sel  = 0;
    m_err  = '0;
    m_nlat = clamp_mode(bus.active_lanes);
  endtask

  task automatic model_edge(input lanes_t lv, input beat_t ld, input logic ro);
    lanes_t rdy;
    bit     empty;
    bit     pop;
    bit     wrp;
    rdy   = m_ready();
    empty = 1;
    for (int i = 0; i < NUM_LANES; i++) if (mq[i].size() != 0) empty = 0;
    pop = m_valid() && ro;
    wrp = pop && (m_sel == m_nlat - 1);
    if (pop) void'(mq[m_sel].pop_front());
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lv[i]) begin
        if (rdy[i]) mq[i].push_back(ld[i*DATA_W +: DATA_W]);
        else m_err[i] = 1'b1;
      end
    end
    if (pop) m_sel = wrp ? 0 : m_sel + 1;
    if (wrp || empty) begin
      m_nlat = clamp_mode(bus.active_lanes);
      if (empty && m_sel >= m_nlat) m_sel = 0;
    end
  endtask

  // Called at a negedge.
  // Drives one cycle of inputs and records any word accepted downstream.
  // Advances the model and returns at the next negedge.
  task automatic tick(input lanes_t lv, input beat_t ld, input logic ro);
    bus.lane_valid = lv;
    bus.lane_data  = ld;
    bus.ready_out  = ro;
    if (bus.valid_out && ro) got.push_back(bus.data_out);
    model_edge(lv, ld, ro);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick('0, '0, 1'b1);
  endtask

  task automatic do_reset(input logic [3:0] al);
    bus.active_lanes = al;
    bus.lane_valid   = '0;
    bus.lane_data    = '0;
    bus.ready_out    = 1'b0;
    reset_L          = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    model_reset();
    got.delete();
  endtask

  task automatic test_reset();
    do_reset(4'd4);
    reset_L = 1'b0;
    #2;
    total++;
    if (bus.data_out !== '0) $display("FAIL reset_data_out: got %h want 0", bus.data_out);
    else passed++;
    total++;
    if (bus.valid_out !== 1'b0) $display("FAIL reset_valid_out: got %b want 0", bus.valid_out);
    else passed++;
    @(negedge clk);
    reset_L = 1'b1;
    model_reset();
    total++;
    if (bus.lane_err !== 4'b0000) $display("FAIL reset_lane_err: got %b want 0000", bus.lane_err);
    else passed++;
    total++;
    if (bus.lane_ready !== 4'b1111) $display("FAIL reset_lane_ready: got %b want 1111", bus.lane_ready);
    else passed++;
  endtask

  task automatic test_basic();
    word_t exp [$];
    exp = '{32'hA0, 32'hB1, 32'hC2, 32'hD3};
    do_reset(4'd4);
    tick(4'b1111, pk(32'hA0, 32'hB1, 32'hC2, 32'hD3), 1'b1);
    total++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== 32'hA0)
      $display("FAIL basic_latency: got valid=%b data=%h want valid=1 data=a0", bus.valid_out, bus.data_out);
    else passed++;
    idle(4);
    total++;
    if (got.size() != exp.size()) $display("FAIL basic_count: got %0d words want %0d", got.size(), exp.size());
    else passed++;
    foreach (exp[k]) begin
      total++;
      if (k >= got.size() || got[k] !== exp[k])
        $display("FAIL basic_word%0d: got %h want %h", k, (k < got.size()) ? got[k] : word_t'('x), exp[k]);
      else passed++;
    end
    total++;
    if (bus.valid_out !== 1'b0) $display("FAIL basic_drained: got valid=%b want 0", bus.valid_out);
    else passed++;
  endtask

  task automatic test_two_lane();
    word_t exp [$];
    exp = '{32'h11, 32'h22, 32'h33, 32'h44};
    do_reset(4'd4);
    bus.active_lanes = 4'd2;
    idle(1);
    total++;
    if (bus.lane_ready !== 4'b0011) $display("FAIL two_lane_ready: got %b want 0011", bus.lane_ready);
    else passed++;
    tick(4'b0011, pk(32'h11, 32'h22, '0, '0), 1'b1);
    tick(4'b0011, pk(32'h33, 32'h44, '0, '0), 1'b1);
    idle(3);
    total++;
    if (got.size() != exp.size()) $display("FAIL two_lane_count: got %0d words want %0d", got.size(), exp.size());
    else passed++;
    foreach (exp[k]) begin
      total++;
      if (k >= got.size() || got[k] !== exp[k])
        $display("FAIL two_lane_word%0d: got %h want %h", k, (k < got.size()) ? got[k] : word_t'('x), exp[k]);
      else passed++;
    end
    total++;
    if (bus.lane_ready[3:2] !== 2'b00) $display("FAIL two_lane_upper_ready: got %b want 00", bus.lane_ready[3:2]);
    else passed++;
  endtask

  task automatic test_overflow();
    do_reset(4'd4);
    for (int k = 1; k <= DEPTH + 1; k++) begin
      tick(4'b0001, pk(w(0, k), '0, '0, '0), 1'b0);
      total++;
      if (bus.lane_ready[0] !== logic'(k < DEPTH))
        $display("FAIL overflow_ready_after_%0d: got %b want %b", k, bus.lane_ready[0], k < DEPTH);
      else passed++;
      total++;
      if (bus.lane_err[0] !== logic'(k > DEPTH))
        $display("FAIL overflow_err_after_%0d: got %b want %b", k, bus.lane_err[0], k > DEPTH);
      else passed++;
    end
    idle(3);
    total++;
    if (got.size() != 1 || got[0] !== w(0, 1))
      $display("FAIL overflow_drain: got %0d words (first %h) want 1 word %h", got.size(),
               (got.size() > 0) ? got[0] : word_t'('x), w(0, 1));
    else passed++;
    total++;
    if (bus.lane_err !== 4'b0001) $display("FAIL overflow_err_sticky: got %b want 0001", bus.lane_err);
    else passed++;
  endtask

  task automatic test_starve();
    word_t exp [$];
    exp = '{w(0, 0), w(1, 9), w(2, 0), w(3, 0), w(0, 1)};
    do_reset(4'd4);
    for (int b = 0; b < DEPTH; b++) tick(4'b1101, pk(w(0, b), '0, w(2, b), w(3, b)), 1'b0);
    total++;
    if (bus.lane_ready !== 4'b0010) $display("FAIL starve_ready: got %b want 0010", bus.lane_ready);
    else passed++;
    idle(6);
    total++;
    if (got.size() != 1 || bus.valid_out !== 1'b0)
      $display("FAIL starve_stall: got %0d words valid=%b want 1 word valid=0", got.size(), bus.valid_out);
    else passed++;
    tick(4'b0010, pk('0, w(1, 9), '0, '0), 1'b1);
    idle(6);
    total++;
    if (got.size() != exp.size()) $display("FAIL starve_count: got %0d words want %0d", got.size(), exp.size());
    else passed++;
    foreach (exp[k]) begin
      total++;
      if (k >= got.size() || got[k] !== exp[k])
        $display("FAIL starve_word%0d: got %h want %h", k, (k < got.size()) ? got[k] : word_t'('x), exp[k]);
      else passed++;
    end
    total++;
    if (bus.valid_out !== 1'b0) $display("FAIL starve_restall: got valid=%b want 0", bus.valid_out);
    else passed++;
  endtask

  task automatic test_async_reset();
    word_t exp [$];
    exp = '{32'h55, 32'h66};
    do_reset(4'd4);
    tick(4'b0111, pk(w(0, 1), w(1, 1), w(2, 1), '0), 1'b0);
    total++;
    if (bus.valid_out !== 1'b1) $display("FAIL areset_buffered: got valid=%b want 1", bus.valid_out);
    else passed++;
    bus.lane_valid = '0;
    bus.ready_out  = 1'b0;
    #1 reset_L = 1'b0;
    #1;
    total++;
    if (bus.valid_out !== 1'b0 || bus.data_out !== '0)
      $display("FAIL areset_immediate: got valid=%b data=%h want valid=0 data=0", bus.valid_out, bus.data_out);
    else passed++;
    #1 reset_L = 1'b1;
    model_reset();
    @(negedge clk);
    idle(4);
    total++;
    if (got.size() != 0 || bus.valid_out !== 1'b0)
      $display("FAIL areset_discard: got %0d stale words valid=%b want 0 words valid=0", got.size(), bus.valid_out);
    else passed++;
    tick(4'b0011, pk(32'h55, 32'h66, '0, '0), 1'b1);
    idle(3);
    foreach (exp[k]) begin
      total++;
      if (k >= got.size() || got[k] !== exp[k])
        $display("FAIL areset_word%0d: got %h want %h", k, (k < got.size()) ? got[k] : word_t'('x), exp[k]);
      else passed++;
    end
  endtask

  task automatic test_mode_change();
    word_t exp [$];
    exp = '{w(0, 0), w(1, 0), w(2, 0), w(3, 0), w(0, 1), w(1, 1), w(0, 2), w(1, 2)};
    do_reset(4'd4);
    tick(4'b1111, pk(w(0, 0), w(1, 0), w(2, 0), w(3, 0)), 1'b0);
    tick(4'b0011, pk(w(0, 1), w(1, 1), '0, '0), 1'b0);
    idle(2);
    bus.active_lanes = 4'd2;
    total++;
    if (bus.lane_ready[3:2] !== 2'b11) $display("FAIL mode_hold_ready: got %b want 11", bus.lane_ready[3:2]);
    else passed++;
    idle(2);
    total++;
    if (bus.lane_ready !== 4'b0011) $display("FAIL mode_applied_ready: got %b want 0011", bus.lane_ready);
    else passed++;
    tick(4'b0011, pk(w(0, 2), w(1, 2), '0, '0), 1'b1);
    idle(4);
    total++;
    if (got.size() != exp.size()) $display("FAIL mode_count: got %0d words want %0d", got.size(), exp.size());
    else passed++;
    foreach (exp[k]) begin
      total++;
      if (k >= got.size() || got[k] !== exp[k])
        $display("FAIL mode_word%0d: got %h want %h", k, (k < got.size()) ? got[k] : word_t'('x), exp[k]);
      else passed++;
    end
  endtask

  task automatic test_random();
    lanes_t lv;
    beat_t  ld;
    logic   ro;
    do_reset(4'd4);
    for (int c = 0; c < 800; c++) begin
      total++;
      if (bus.lane_ready !== m_ready())
        $display("FAIL rand_ready c%0d: got %b want %b", c, bus.lane_ready, m_ready());
      else passed++;
      total++;
      if (bus.valid_out !== m_valid())
        $display("FAIL rand_valid c%0d: got %b want %b", c, bus.valid_out, m_valid());
      else passed++;
      if (m_valid()) begin
        total++;
        if (bus.data_out !== m_head())
          $display("FAIL rand_data c%0d: got %h want %h", c, bus.data_out, m_head());
        else passed++;
      end
      total++;
      if (bus.lane_err !== m_err)
        $display("FAIL rand_err c%0d: got %b want %b", c, bus.lane_err, m_err);
      else passed++;
      if ($urandom_range(0, 49) == 0) bus.active_lanes = 4'($urandom_range(0, 15));
      lv = lanes_t'($urandom_range(0, (1 << NUM_LANES) - 1));
      for (int i = 0; i < NUM_LANES; i++) ld[i*DATA_W +: DATA_W] = $urandom;
      ro = ($urandom_range(0, 3) != 0);
      tick(lv, ld, ro);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_two_lane();
    test_overflow();
    test_starve();
    test_async_reset();
    test_mode_change();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/lane_unstripe_n.md
LANE_UNSTRIPE_N -- requirements
Module: lane_unstripe_n

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of one lane word.
REQ-002 SHALL have parameter NUM_LANES, default 4, number of input lanes (legal 2..8).
REQ-003 SHALL have parameter DEPTH, default 4, words per lane FIFO (power of 2, legal 2..16).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_L  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port active_lanes  input  4  number of lanes in use (mode).
REQ-007 SHALL have port lane_data  input  NUM_LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port lane_valid  input  NUM_LANES  per-lane word-present strobe.
REQ-009 SHALL have port lane_ready  output  NUM_LANES  per-lane space-available flag.
REQ-010 SHALL have port data_out  output  DATA_W  merged output word.
REQ-011 SHALL have port valid_out  output  1  data_out holds a valid word.
REQ-012 SHALL have port ready_out  input  1  downstream accepts data_out this cycle.
REQ-013 SHALL have port lane_err  output  NUM_LANES  sticky per-lane overflow/protocol flag.

Function
REQ-014 SHALL hold one DEPTH-entry FIFO per lane: write pointer, read pointer, count of clog2(DEPTH+1) bits; pointers wrap modulo DEPTH.
REQ-015 SHALL compute effective lane count N_eff = 1 if active_lanes==0, NUM_LANES if active_lanes>NUM_LANES, else active_lanes.
REQ-016 SHALL drive lane_ready[i] = (count_i != DEPTH) && (i < N_eff_latched); it does not account for a same-cycle pop.
REQ-017 SHALL push lane_data word i into FIFO i on an edge where lane_valid[i] && lane_ready[i].
REQ-018 SHALL, when lane_valid[i] && !lane_ready[i], drop the word, leave FIFO i unchanged, and set lane_err[i] until reset.
REQ-019 SHALL keep a lane pointer sel (0..NUM_LANES-1), reset to 0; data_out = head of FIFO sel, valid_out = (count_sel != 0); data_out is don't-care when valid_out=0.
REQ-020 SHALL pop FIFO sel on an edge where valid_out && ready_out, and then advance sel to sel+1, or to 0 when sel == N_eff_latched-1.
REQ-021 SHALL NOT advance sel while FIFO sel is empty (strict round-robin; output order = lane0, lane1, ..., lane N-1, lane0, ...).
REQ-022 SHALL latch N_eff into N_eff_latched only on edges where sel wraps to 0 or when all FIFOs are empty; otherwise it holds.
REQ-023 SHALL permit simultaneous push and pop on the same FIFO in one cycle; count unchanged, both pointers advance.
REQ-024 SHALL give a minimum latency of 1 clk: a word pushed at edge t appears on data_out after edge t if its lane is sel and FIFO was empty.
REQ-025 SHALL hold data_out and valid_out stable while valid_out && !ready_out.

Reset
REQ-026 SHALL on reset_L=0 asynchronously clear all counts and pointers, sel=0, lane_err=0, N_eff_latched=NUM_LANES clamp of active_lanes per REQ-015 evaluated at deassertion edge, valid_out=0.
REQ-027 SHALL discard all buffered words on reset mid-operation; first output after release comes from lane 0.
REQ-028 SHALL leave data_out at 0 during reset.

Verification
REQ-029 SHALL cover: NUM_LANES=4, active_lanes=4, one beat with words A0,B1,C2,D3 on lanes 0..3, ready_out=1 -> data_out A0,B1,C2,D3 on four consecutive cycles, first one cycle after push.
REQ-030 SHALL cover: active_lanes=2, lanes 0,1 fed 0x11,0x22 then 0x33,0x44 -> output 0x11,0x22,0x33,0x44; lane_ready[3:2]=0.
REQ-031 SHALL cover: ready_out=0, lane 0 fed DEPTH+1 words -> lane_ready[0]=0 after 4th word, 5th dropped, lane_err[0]=1 and stays 1.
REQ-032 SHALL cover: lane 1 starved while lanes 0,2,3 full -> exactly one lane-0 word out, then valid_out=0 until lane 1 pushed.
REQ-033 SHALL cover: reset_L pulsed low asynchronously with 3 words buffered -> valid_out=0 immediately, counts 0, sel=0.
REQ-034 SHALL cover: active_lanes changed 4->2 with sel=2 -> lanes 2,3 drained, new mode applied after wrap to 0.
